// File: rtl/nand_sweep_checker.sv
// rtl/nand_sweep_checker.sv - exhaustive truth-table sweep and checker for a 2-input NAND cell
// Drives 00,01,10,11 onto the gate, samples dout after settling, counts vectors and mismatches.
module nand_sweep_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int LOOPS      = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dout,
    output logic             din_a,
    output logic             din_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] vec_cnt
);
    localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int LOOPS_EFF  = (LOOPS < 1) ? 1 : LOOPS;
    localparam int SC_W       = (SETTLE_EFF < 2) ? 1 : $clog2(SETTLE_EFF);
    localparam int LP_W       = (LOOPS_EFF < 2) ? 1 : $clog2(LOOPS_EFF);

    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_EFF - 1);
    localparam logic [LP_W-1:0]  LOOP_LAST   = LP_W'(LOOPS_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_vec_idx;
    logic [LP_W-1:0]  r_loop_idx;
    logic [SC_W-1:0]  r_settle;
    logic             r_din_a;
    logic             r_din_b;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_vec_cnt;

    logic             w_expected;
    logic             w_mismatch;
    logic             w_last;
    logic [1:0]       w_vec_idx_nxt;
    logic [CNT_W-1:0] w_vec_cnt_nxt;
    logic [CNT_W-1:0] w_err_cnt_nxt;

    // Compare against the vector currently on the gate, not the one about to be applied.
    assign w_expected    = ~(r_din_a & r_din_b);
    assign w_mismatch    = dout ^ w_expected;
    assign w_last        = (r_vec_idx == 2'd3) && (r_loop_idx == LOOP_LAST);
    assign w_vec_idx_nxt = r_vec_idx + 2'd1;
    assign w_vec_cnt_nxt = (r_vec_cnt == CNT_MAX) ? r_vec_cnt : r_vec_cnt + CNT_ONE;
    assign w_err_cnt_nxt = (w_mismatch && (r_err_cnt != CNT_MAX)) ? r_err_cnt + CNT_ONE
                                                                  : r_err_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_APPLY;
            S_APPLY:  w_next = S_SETTLE;
            S_SETTLE: if (r_settle == SETTLE_LAST) w_next = S_CHECK;
            S_CHECK:  w_next = w_last ? S_DONE : S_APPLY;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vec_idx  <= 2'd0;
            r_loop_idx <= '0;
            r_settle   <= '0;
            r_din_a    <= 1'b0;
            r_din_b    <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_vec_cnt  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_din_a <= 1'b0;
                    r_din_b <= 1'b0;
                    if (start) begin
                        r_err_cnt  <= '0;
                        r_vec_cnt  <= '0;
                        r_vec_idx  <= 2'd0;
                        r_loop_idx <= '0;
                    end
                end
                S_APPLY: begin
                    r_settle <= '0;
                end
                S_SETTLE: begin
                    r_settle <= r_settle + 1'b1;
                end
                S_CHECK: begin
                    r_vec_cnt <= w_vec_cnt_nxt;
                    r_err_cnt <= w_err_cnt_nxt;
                    if (w_last) begin
                        // Final count is known here, so pass lands on the same edge as done.
                        r_pass  <= (w_err_cnt_nxt == '0);
                        r_din_a <= 1'b0;
                        r_din_b <= 1'b0;
                    end else begin
                        r_vec_idx <= w_vec_idx_nxt;
                        if (r_vec_idx == 2'd3) r_loop_idx <= r_loop_idx + 1'b1;
                        r_din_a <= w_vec_idx_nxt[1];
                        r_din_b <= w_vec_idx_nxt[0];
                    end
                end
                S_DONE: begin
                    r_din_a <= 1'b0;
                    r_din_b <= 1'b0;
                end
                default: begin
                    r_din_a <= 1'b0;
                    r_din_b <= 1'b0;
                end
            endcase
        end
    end

    assign din_a   = r_din_a;
    assign din_b   = r_din_b;
    assign busy    = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done    = (r_state == S_DONE);
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;
    assign vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// tb/tb_nand_sweep_checker.sv - scoreboard bench for nand_sweep_checker
// Instance 0 uses defaults, instance 1 uses LOOPS=3, CNT_W=3; gate behaviour is chosen per run.
module tb_nand_sweep_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] start = 2'b00;
    logic [1:0] dout;
    logic [1:0] da, db, busy, done, pass;
    logic [7:0] e0, v0;
    logic [2:0] e1, v1;
    logic [7:0] errc [2];
    logic [7:0] vecc [2];
    int         mode [2] = '{0, 0};
    int         cyc = 0;
    int         n_vec = 0;
    int         n_mis = 0;

    typedef struct {
        int start;
        int lat;
        int vec;
        int err;
        int pass;
    } exp_t;

    exp_t       sbq [2][$];
    logic [1:0] dq  [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        errc[0] = e0;
        vecc[0] = v0;
        errc[1] = {5'd0, e1};
        vecc[1] = {5'd0, v1};
    end

    // Gate under test: 0 = real NAND, 1 = output stuck at 1, 2 = AND (inverted NAND).
    always_comb begin
        dout = 2'b00;
        for (int d = 0; d < 2; d++) begin
            case (mode[d])
                0:       dout[d] = ~(da[d] & db[d]);
                1:       dout[d] = 1'b1;
                default: dout[d] = da[d] & db[d];
            endcase
        end
    end

    nand_sweep_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .dout(dout[0]),
        .din_a(da[0]), .din_b(db[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_cnt(e0), .vec_cnt(v0)
    );

    nand_sweep_checker #(.SETTLE_CYC(2), .LOOPS(3), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .dout(dout[1]),
        .din_a(da[1]), .din_b(db[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_cnt(e1), .vec_cnt(v1)
    );

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    function automatic int loops_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 8 : 3;
    endfunction

    // Reference: walk the truth table LOOPS times and count disagreements with NAND.
    function automatic exp_t model(input int d, input int m, input int s);
        exp_t e;
        int   n    = 4 * loops_of(d);
        int   maxc = (1 << width_of(d)) - 1;
        int   raw  = 0;
        for (int v = 0; v < n; v++) begin
            int a    = (v % 4) / 2;
            int b    = v % 2;
            int nand_v = (a & b) ? 0 : 1;
            int g    = (m == 0) ? nand_v : (m == 1) ? 1 : (a & b);
            if (g != nand_v) raw++;
        end
        e.start = s;
        e.lat   = n * 4;
        e.vec   = (n > maxc) ? maxc : n;
        e.err   = (raw > maxc) ? maxc : raw;
        e.pass  = (raw == 0) ? 1 : 0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (busy[d]) begin
                    if (dq[d].size() == 0) chk("busy_too_long", d, 1, 0);
                    else chk("din_vector", d, int'({da[d], db[d]}), int'(dq[d].pop_front()));
                end
                if (done[d]) begin
                    if (sbq[d].size() == 0) chk("unexpected_done", d, 1, 0);
                    else begin
                        e = sbq[d].pop_front();
                        chk("done_latency", d, cyc - e.start, e.lat);
                        chk("vec_cnt", d, int'(vecc[d]), e.vec);
                        chk("err_cnt", d, int'(errc[d]), e.err);
                        chk("pass", d, int'(pass[d]), e.pass);
                        chk("din_idle", d, int'({da[d], db[d]}), 0);
                        chk("busy_at_done", d, int'(busy[d]), 0);
                        chk("trace_left", d, dq[d].size(), 0);
                    end
                end
            end
        end
    end

    task automatic start_run(input int d, input int m);
        int t = 0;
        while ((busy[d] || done[d]) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("idle_timeout", d, 1, 0);
        mode[d] = m;
        sbq[d].push_back(model(d, m, cyc + 1));
        for (int k = 0; k < 16 * loops_of(d); k++) dq[d].push_back(2'((k / 4) % 4));
        start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic finish_run(input int d);
        int t = 0;
        while (sbq[d].size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) begin
            chk("run_timeout", d, 1, 0);
            sbq[d].delete();
            dq[d].delete();
        end
    endtask

    // Disturb re-pulses start while vector 01 settles and again during the DONE cycle.
    task automatic run(input int d, input int m, input bit disturb);
        start_run(d, m);
        if (disturb) begin
            repeat (5) @(posedge clk);
            #1 start[d] = 1'b1;
            @(posedge clk);
            #1 start[d] = 1'b0;
            repeat (10) @(posedge clk);
            #1 start[d] = 1'b1;
            @(posedge clk);
            #1 start[d] = 1'b0;
        end
        finish_run(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_din"}, d, int'({da[d], db[d]}), 0);
            chk({tag, "_busy"}, d, int'(busy[d]), 0);
            chk({tag, "_done"}, d, int'(done[d]), 0);
            chk({tag, "_pass"}, d, int'(pass[d]), 0);
            chk({tag, "_err"}, d, int'(errc[d]), 0);
            chk({tag, "_vec"}, d, int'(vecc[d]), 0);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run(0, 0, 1'b0);
        run(0, 1, 1'b0);
        run(1, 2, 1'b0);
        run(0, 0, 1'b1);

        start_run(0, 0);
        repeat (11) @(posedge clk);
        chk("vec_before_rst", 0, int'(vecc[0]), 2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrun_reset");
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            dq[d].delete();
        end
        @(posedge clk);
        #1 rst = 1'b0;
        run(0, 0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            int d = int'($urandom_range(0, 1));
            int m = int'($urandom_range(0, 2));
            bit z = (d == 0) && ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run(d, m, z);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_mis);
        $fatal(1);
    end
endmodule
